gelato_warp_scheduler: RTL and testbench

Fetch-stage warp scheduler: arbitrates among `WARP_NUM` warps whose split tables present a valid PC and issues one warp per cycle to instruction fetch.
- Each issued warp is marked in-flight until decode reports back through the split table's activate event, so a warp never has two fetches outstanding.
- Sits between the per-warp split tables (PC table side) and the fetch unit.
- Fair round-robin selection; a registered, stallable valid/ready output.

---
 rtl/gelato_warp_scheduler_pkg.sv | 13 +
 rtl/gelato_warp_scheduler_rr_arbiter.sv | 29 ++
 rtl/gelato_warp_scheduler.sv | 153 +++++++++++++++
 tb/tb_gelato_warp_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_warp_scheduler_pkg.sv
// Shared types for the gelato fetch-stage warp scheduler (package gelato_types).
// The scheduler's warp index, PC and split-entry widths all come from here.
package gelato_types;

    localparam int GELATO_WARP_NUM        = 4;
    localparam int GELATO_PC_WIDTH        = 32;
    localparam int GELATO_SPLIT_NUM_WIDTH = 2;

    typedef logic [$clog2(GELATO_WARP_NUM)-1:0] warp_num_t;
    typedef logic [GELATO_PC_WIDTH-1:0]         pc_t;
    typedef logic [GELATO_SPLIT_NUM_WIDTH-1:0]  split_table_num_t;

endpackage

// File: rtl/gelato_warp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester strictly after ptr
// wins, wrapping modulo WARP_NUM (WARP_NUM must be a power of two).
module gelato_rr_arbiter #(
    parameter int  WARP_NUM = 4,
    localparam int IDX_W    = $clog2(WARP_NUM)
) (
    input  logic [WARP_NUM-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_idx
);

    logic [IDX_W-1:0] cand;

    // Index arithmetic wraps naturally because WARP_NUM is a power of two.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= WARP_NUM; i++) begin
            cand = ptr + IDX_W'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Fetch-stage warp scheduler: round-robin issue of one warp per cycle into a
// stallable slot. Define GELATO_WARP_SCHED_PERF_EN to add issue/stall counters.
module gelato_warp_scheduler
    import gelato_types::*;
#(
    parameter int  WARP_NUM        = GELATO_WARP_NUM,
    parameter int  PC_WIDTH        = GELATO_PC_WIDTH,
    parameter int  SPLIT_NUM_WIDTH = GELATO_SPLIT_NUM_WIDTH,
    localparam int WID_W           = $clog2(WARP_NUM)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rdy,
    input  logic                                init_valid,
    input  logic [WARP_NUM-1:0]                 pc_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]        pc,
    input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] pc_split_num,
    input  logic                                activate_valid,
    input  logic [WID_W-1:0]                    activate_warp_num,
    output logic                                fetch_valid,
    input  logic                                fetch_ready,
    output logic [WID_W-1:0]                    fetch_warp_num,
    output logic [PC_WIDTH-1:0]                 fetch_pc,
    output logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_num,
    output logic                                idle
`ifdef GELATO_WARP_SCHED_PERF_EN
    ,
    output logic [31:0]                         perf_issue_cnt,
    output logic [31:0]                         perf_stall_cnt
`endif
);

    logic [WARP_NUM-1:0] in_flight_q, in_flight_d;
    warp_num_t           last_grant_q, last_grant_d;
    logic                fetch_valid_q, fetch_valid_d;
    warp_num_t           fetch_warp_num_q, fetch_warp_num_d;
    pc_t                 fetch_pc_q, fetch_pc_d;
    split_table_num_t    fetch_split_num_q, fetch_split_num_d;

    logic [WARP_NUM-1:0] slot_mask;
    logic [WARP_NUM-1:0] eligible;
    logic                grant_valid;
    warp_num_t           grant_idx;
    logic                accept;
    logic                slot_free;

    // The warp sitting in the slot is not yet in flight, so mask it separately.
    always_comb begin
        slot_mask = '0;
        if (fetch_valid_q) slot_mask[fetch_warp_num_q] = 1'b1;
    end

    assign eligible  = pc_valid & ~in_flight_q & ~slot_mask;
    assign accept    = fetch_valid_q & fetch_ready;
    assign slot_free = ~fetch_valid_q | fetch_ready;

    gelato_rr_arbiter #(.WARP_NUM(WARP_NUM)) u_arb (
        .req         (eligible),
        .ptr         (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        in_flight_d       = in_flight_q;
        last_grant_d      = last_grant_q;
        fetch_valid_d     = fetch_valid_q;
        fetch_warp_num_d  = fetch_warp_num_q;
        fetch_pc_d        = fetch_pc_q;
        fetch_split_num_d = fetch_split_num_q;
        if (rdy) begin
            if (init_valid) begin
                in_flight_d       = '0;
                last_grant_d      = warp_num_t'(WARP_NUM - 1);
                fetch_valid_d     = 1'b0;
                fetch_warp_num_d  = '0;
                fetch_pc_d        = '0;
                fetch_split_num_d = '0;
            end else begin
                // Clear before set so an accept wins over a same-warp activate.
                if (activate_valid) in_flight_d[activate_warp_num] = 1'b0;
                if (accept)         in_flight_d[fetch_warp_num_q]  = 1'b1;
                if (slot_free) begin
                    fetch_valid_d = grant_valid;
                    if (grant_valid) begin
                        last_grant_d      = grant_idx;
                        fetch_warp_num_d  = grant_idx;
                        fetch_pc_d        = pc[int'(grant_idx)*PC_WIDTH +: PC_WIDTH];
                        fetch_split_num_d =
                            pc_split_num[int'(grant_idx)*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q       <= '0;
            last_grant_q      <= warp_num_t'(WARP_NUM - 1);
            fetch_valid_q     <= 1'b0;
            fetch_warp_num_q  <= '0;
            fetch_pc_q        <= '0;
            fetch_split_num_q <= '0;
        end else begin
            in_flight_q       <= in_flight_d;
            last_grant_q      <= last_grant_d;
            fetch_valid_q     <= fetch_valid_d;
            fetch_warp_num_q  <= fetch_warp_num_d;
            fetch_pc_q        <= fetch_pc_d;
            fetch_split_num_q <= fetch_split_num_d;
        end
    end

    assign fetch_valid     = fetch_valid_q;
    assign fetch_warp_num  = fetch_warp_num_q;
    assign fetch_pc        = fetch_pc_q;
    assign fetch_split_num = fetch_split_num_q;
    assign idle            = ~|eligible & ~|in_flight_q & ~fetch_valid_q;

`ifdef GELATO_WARP_SCHED_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (rdy) begin
            if (init_valid) begin
                perf_issue_d = '0;
                perf_stall_d = '0;
            end else begin
                if (accept)                        perf_issue_d = perf_issue_q + 32'd1;
                if (fetch_valid_q && !fetch_ready) perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Scoreboard bench for gelato_warp_scheduler: issued transfers are checked by a
// monitor against a queue of expected warps; cycle-level checks run inline.
module tb_gelato_warp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        init_valid;
    logic [3:0]  pc_valid;
    logic [127:0] pc;
    logic [7:0]  pc_split_num;
    logic        activate_valid;
    logic [1:0]  activate_warp_num;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [1:0]  fetch_warp_num;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_split_num;
    logic        idle;
`ifdef GELATO_WARP_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] pcm [4];

    typedef struct {
        int          w;
        logic [31:0] pc;
        logic [1:0]  sp;
    } exp_t;
    exp_t expq[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) pc[i*32 +: 32] = pcm[i];
    end
    assign pc_split_num = {2'd3, 2'd2, 2'd1, 2'd0};

    gelato_warp_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rdy               (rdy),
        .init_valid        (init_valid),
        .pc_valid          (pc_valid),
        .pc                (pc),
        .pc_split_num      (pc_split_num),
        .activate_valid    (activate_valid),
        .activate_warp_num (activate_warp_num),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_warp_num    (fetch_warp_num),
        .fetch_pc          (fetch_pc),
        .fetch_split_num   (fetch_split_num),
        .idle              (idle)
`ifdef GELATO_WARP_SCHED_PERF_EN
        ,
        .perf_issue_cnt    (perf_issue_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int w);
        exp_t e;
        e.w  = w;
        e.pc = pcm[w];
        e.sp = 2'(w);
        expq.push_back(e);
    endtask

    // Monitor: every accepted transfer must match the oldest expected issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rdy && !init_valid && fetch_valid && fetch_ready) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got warp %0d, expected no issue", fetch_warp_num);
                end else begin
                    e = expq.pop_front();
                    chk("sb_warp", 32'(fetch_warp_num), e.w);
                    chk("sb_pc", fetch_pc, e.pc);
                    chk("sb_split", 32'(fetch_split_num), 32'(e.sp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; init_valid = 1'b0; pc_valid = 4'b0000;
        activate_valid = 1'b0; activate_warp_num = 2'd0; fetch_ready = 1'b0;
        for (int i = 0; i < 4; i++) pcm[i] = 32'h1000 + 32'(i * 16);

        // Reset values
        @(negedge clk);
        chk("rst_valid", 32'(fetch_valid), 0);
        chk("rst_warp", 32'(fetch_warp_num), 0);
        chk("rst_pc", fetch_pc, 0);
        chk("rst_split", 32'(fetch_split_num), 0);
        chk("rst_idle", 32'(idle), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // All warps runnable: 0,1,2,3 back to back, then drained
        pc_valid = 4'b1111; fetch_ready = 1'b1;
        for (int k = 0; k < 4; k++) push(k);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            chk("t1_valid", 32'(fetch_valid), 1);
            chk("t1_warp", 32'(fetch_warp_num), k);
        end
        @(posedge clk); @(negedge clk);
        chk("t1_drain", 32'(fetch_valid), 0);
        chk("t1_idle", 32'(idle), 0);

        // Reactivate warp 2 with a new PC: reissued 2 cycles after the pulse
        @(posedge clk); #1;
        activate_valid = 1'b1; activate_warp_num = 2'd2; pcm[2] = 32'h2222_0000; push(2);
        @(negedge clk); chk("t2_c0", 32'(fetch_valid), 0);
        @(posedge clk); #1 activate_valid = 1'b0;
        @(negedge clk); chk("t2_c1", 32'(fetch_valid), 0);
        @(posedge clk); @(negedge clk);
        chk("t2_c2_valid", 32'(fetch_valid), 1);
        chk("t2_c2_warp", 32'(fetch_warp_num), 2);
        chk("t2_c2_pc", fetch_pc, 32'h2222_0000);

        // Stall warp 1 for 5 cycles while its PC changes underneath
        @(posedge clk); #1;
        fetch_ready = 1'b0; activate_valid = 1'b1; activate_warp_num = 2'd1; push(1);
        @(posedge clk); #1 activate_valid = 1'b0;
        @(posedge clk); #1 pcm[1] = 32'hdead_beef;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_valid", 32'(fetch_valid), 1);
            chk("t3_warp", 32'(fetch_warp_num), 1);
            chk("t3_pc", fetch_pc, 32'h0000_1010);
            @(posedge clk); #1;
        end
`ifdef GELATO_WARP_SCHED_PERF_EN
        chk("t3_perf_stall", perf_stall_cnt, 5);
        chk("t3_perf_issue", perf_issue_cnt, 5);
`endif
        fetch_ready = 1'b1;

        // init_valid with warp 3 in the slot and the others in flight
        @(posedge clk); #1;
        fetch_ready = 1'b0; activate_valid = 1'b1; activate_warp_num = 2'd3;
        @(posedge clk); #1 activate_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_slot_warp", 32'(fetch_warp_num), 3);
        chk("t5_slot_valid", 32'(fetch_valid), 1);
        @(posedge clk); #1;
        init_valid = 1'b1; fetch_ready = 1'b1; activate_valid = 1'b1; activate_warp_num = 2'd0;
        @(posedge clk); #1;
        init_valid = 1'b0; activate_valid = 1'b0;
        for (int k = 0; k < 4; k++) push(k);
        @(negedge clk);
        chk("t5_valid", 32'(fetch_valid), 0);
        chk("t5_warp", 32'(fetch_warp_num), 0);
        chk("t5_pc", fetch_pc, 0);
`ifdef GELATO_WARP_SCHED_PERF_EN
        chk("t5_perf_issue", perf_issue_cnt, 0);
        chk("t5_perf_stall", perf_stall_cnt, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            chk("t5_warp_seq", 32'(fetch_warp_num), k);
        end
        @(posedge clk); @(negedge clk);
        chk("t5_drain", 32'(fetch_valid), 0);

        // last_grant=0 with warps 0 and 3 runnable: 3 wins, then 0
        @(posedge clk); #1;
        init_valid = 1'b1; pc_valid = 4'b0001;
        @(posedge clk); #1;
        init_valid = 1'b0; push(0);
        @(posedge clk); @(negedge clk);
        chk("t4_first", 32'(fetch_warp_num), 0);
        @(posedge clk); #1;
        activate_valid = 1'b1; activate_warp_num = 2'd0;
        @(posedge clk); #1;
        activate_valid = 1'b0; pc_valid = 4'b1001; push(3); push(0);
        @(negedge clk); chk("t4_gap", 32'(fetch_valid), 0);
        @(posedge clk); @(negedge clk);
        chk("t4_rr_a", 32'(fetch_warp_num), 3);
        @(posedge clk); @(negedge clk);
        chk("t4_rr_b", 32'(fetch_warp_num), 0);
        chk("t4_rr_b_valid", 32'(fetch_valid), 1);

        // rdy low freezes everything, including activate and accept
        @(posedge clk); #1;
        fetch_ready = 1'b0; activate_valid = 1'b1; activate_warp_num = 2'd3; push(3);
        @(posedge clk); #1 activate_valid = 1'b0;
        @(posedge clk); #1;
        rdy = 1'b0; activate_valid = 1'b1; activate_warp_num = 2'd0; fetch_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_valid", 32'(fetch_valid), 1);
            chk("t6_warp", 32'(fetch_warp_num), 3);
            @(posedge clk); #1;
        end
        rdy = 1'b1; activate_valid = 1'b0;
        @(negedge clk); chk("t6_held", 32'(fetch_warp_num), 3);
        @(posedge clk); @(negedge clk);
        chk("t6_no_reissue", 32'(fetch_valid), 0);
        chk("t6_idle", 32'(idle), 0);
`ifdef GELATO_WARP_SCHED_PERF_EN
        chk("t6_perf_issue", perf_issue_cnt, 4);
        chk("t6_perf_stall", perf_stall_cnt, 0);
`endif

        // Flush with nothing runnable: idle
        @(posedge clk); #1;
        pc_valid = 4'b0000; init_valid = 1'b1;
        @(posedge clk); #1 init_valid = 1'b0;
        @(negedge clk);
        chk("end_idle", 32'(idle), 1);
        chk("end_valid", 32'(fetch_valid), 0);
        chk("sb_empty", 32'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
